// File: rtl/mem_rdata_ctrl.sv
// MEM-stage load response controller: tracks outstanding data requests,
// discards stale responses after a flush, and buffers load data while WB stalls.
module mem_rdata_ctrl #(
   parameter int DATA_W    = 32,
   parameter int MAX_OUTST = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line1_valid_i,
   input  logic              line2_valid_i,
   input  logic              load_wait_i,
   input  logic              req_accept_i,
   input  logic              data_ok_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              excep_flush_i,
   input  logic              next_allowin_i,
   output logic              now_allowin_o,
   output logic              line1_to_next_valid_o,
   output logic              line2_to_next_valid_o,
   output logic [DATA_W-1:0] load_rdata_o,
   output logic [1:0]        outst_o,
   output logic [1:0]        discard_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      BUF  = 2'd2
   } state_t;

   localparam logic [1:0] OUTST_MAX = 2'(MAX_OUTST);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        outst;
   logic [1:0]        outst_nxt;
   logic [1:0]        discard;
   logic [1:0]        discard_nxt;
   logic [DATA_W-1:0] buffer;
   logic              group_valid;
   logic              live_ok;
   logic              stale_ok;
   logic              accept_ok;
   logic              ready;
   logic              load_buf;

   assign group_valid = line1_valid_i | line2_valid_i;
   assign live_ok     = data_ok_i & (discard == 2'd0);
   assign stale_ok    = data_ok_i & (discard != 2'd0);
   // A live response only belongs to the MEM group when that group is waiting on a load.
   assign accept_ok   = live_ok & group_valid & load_wait_i;

   always_comb begin
      outst_nxt = outst;
      if (req_accept_i && !data_ok_i && outst != OUTST_MAX)
         outst_nxt = outst + 2'd1;
      else if (data_ok_i && !req_accept_i && outst != 2'd0)
         outst_nxt = outst - 2'd1;

      discard_nxt = discard;
      if (stale_ok)
         discard_nxt = discard - 2'd1;
      // Everything still in flight after this cycle belongs to flushed instructions.
      if (excep_flush_i)
         discard_nxt = outst_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept_ok)
               state_nxt = next_allowin_i ? IDLE : BUF;
            else if (group_valid && load_wait_i && !live_ok)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (accept_ok)
               state_nxt = next_allowin_i ? IDLE : BUF;
         end
         BUF: begin
            if (next_allowin_i)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (excep_flush_i)
         state_nxt = IDLE;
   end

   assign load_buf = (state_nxt == BUF) && (state != BUF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         outst   <= 2'd0;
         discard <= 2'd0;
         buffer  <= '0;
      end else begin
         state   <= state_nxt;
         outst   <= outst_nxt;
         discard <= discard_nxt;
         if (load_buf)
            buffer <= rdata_i;
      end
   end

   assign ready                 = !load_wait_i | live_ok | (state == BUF);
   assign load_rdata_o          = (state == BUF) ? buffer : rdata_i;
   assign line1_to_next_valid_o = line1_valid_i & ready & !excep_flush_i;
   assign line2_to_next_valid_o = line2_valid_i & ready & !excep_flush_i;
   assign now_allowin_o         = !group_valid | (ready & next_allowin_i);
   assign outst_o               = outst;
   assign discard_o             = discard;

endmodule

// File: tb/tb_mem_rdata_ctrl.sv
// Scoreboard bench for mem_rdata_ctrl: a queue-of-pending-requests reference model
// predicts each handoff to WB, and an independent monitor checks what the DUT presents.
module tb_mem_rdata_ctrl;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              line1_valid_i, line2_valid_i, load_wait_i;
   logic              req_accept_i, data_ok_i, excep_flush_i, next_allowin_i;
   logic [DATA_W-1:0] rdata_i;
   logic              now_allowin_o, line1_to_next_valid_o, line2_to_next_valid_o;
   logic [DATA_W-1:0] load_rdata_o;
   logic [1:0]        outst_o, discard_o;

   mem_rdata_ctrl #(.DATA_W(DATA_W), .MAX_OUTST(2)) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .line1_valid_i         (line1_valid_i),
      .line2_valid_i         (line2_valid_i),
      .load_wait_i           (load_wait_i),
      .req_accept_i          (req_accept_i),
      .data_ok_i             (data_ok_i),
      .rdata_i               (rdata_i),
      .excep_flush_i         (excep_flush_i),
      .next_allowin_i        (next_allowin_i),
      .now_allowin_o         (now_allowin_o),
      .line1_to_next_valid_o (line1_to_next_valid_o),
      .line2_to_next_valid_o (line2_to_next_valid_o),
      .load_rdata_o          (load_rdata_o),
      .outst_o               (outst_o),
      .discard_o             (discard_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        l1;
      logic        l2;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   bit          pend_q[$];
   bit          held_valid;
   logic [31:0] held_data;
   bit          exp_allowin;
   int          tests_run = 0;
   int          failed    = 0;
   int          cycle_cnt = 0;
   exp_t        mon_e;

   always @(posedge clk) cycle_cnt++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int staleCount();
      int n = 0;
      foreach (pend_q[i]) if (pend_q[i]) n++;
      return n;
   endfunction

   task automatic clearModel();
      pend_q.delete();
      held_valid = 1'b0;
      held_data  = '0;
   endtask

   task automatic zeroInputs();
      line1_valid_i  = 1'b0;
      line2_valid_i  = 1'b0;
      load_wait_i    = 1'b0;
      req_accept_i   = 1'b0;
      data_ok_i      = 1'b0;
      rdata_i        = '0;
      excep_flush_i  = 1'b0;
      next_allowin_i = 1'b0;
   endtask

   // One cycle: drive inputs, predict outputs from the pending-request queue,
   // check registered counters, then advance the model for the coming edge.
   task automatic applyStimulus(input bit l1, input bit l2, input bit lw, input bit req,
                                input bit dok, input logic [31:0] rd, input bit flush,
                                input bit na);
      bit   live, ready, grp;
      int   sz, exp_o, exp_d;
      exp_t e;
      @(posedge clk);
      #1;
      line1_valid_i  = l1;
      line2_valid_i  = l2;
      load_wait_i    = lw;
      req_accept_i   = req;
      data_ok_i      = dok;
      rdata_i        = rd;
      excep_flush_i  = flush;
      next_allowin_i = na;

      grp         = l1 | l2;
      live        = dok && (pend_q.size() == 0 || !pend_q[0]);
      ready       = !lw || live || held_valid;
      exp_allowin = !grp || (ready && na);
      if (grp && ready && !flush) begin
         e.cyc  = cycle_cnt;
         e.l1   = l1;
         e.l2   = l2;
         e.data = held_valid ? held_data : rd;
         sb_q.push_back(e);
      end
      exp_o = pend_q.size();
      exp_d = staleCount();

      @(negedge clk);
      checkOutput("outst", 32'(outst_o), exp_o);
      checkOutput("discard", 32'(discard_o), exp_d);
      checkOutput("now_allowin", 32'(now_allowin_o), 32'(exp_allowin));

      sz = pend_q.size();
      if (dok && sz > 0) void'(pend_q.pop_front());
      if (req && !(dok && sz == 0) && pend_q.size() < 2) pend_q.push_back(1'b0);
      if (flush) foreach (pend_q[i]) pend_q[i] = 1'b1;
      if (flush) held_valid = 1'b0;
      else if (held_valid) begin
         if (na) held_valid = 1'b0;
      end else if (live && grp && lw && !na) begin
         held_valid = 1'b1;
         held_data  = rd;
      end
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1;
      zeroInputs();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clearModel();
   endtask

   // Monitor: every presented handoff must match the oldest prediction for this cycle.
   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cycle_cnt) begin
         mon_e = sb_q.pop_front();
         tests_run++;
         failed++;
         $display("[TB] FAIL handoff_missing: got none, expected data 0x%0h in cycle %0d", mon_e.data, mon_e.cyc);
      end
      if (line1_to_next_valid_o || line2_to_next_valid_o) begin
         tests_run++;
         if (sb_q.size() == 0 || sb_q[0].cyc != cycle_cnt) begin
            failed++;
            $display("[TB] FAIL handoff_unexpected: got lines %b%b data 0x%0h, expected none (cycle %0d)",
                     line1_to_next_valid_o, line2_to_next_valid_o, load_rdata_o, cycle_cnt);
         end else begin
            mon_e = sb_q.pop_front();
            if ({line1_to_next_valid_o, line2_to_next_valid_o, load_rdata_o} !==
                {mon_e.l1, mon_e.l2, mon_e.data}) begin
               failed++;
               $display("[TB] FAIL handoff_data: got lines %b%b data 0x%0h, expected lines %b%b data 0x%0h",
                        line1_to_next_valid_o, line2_to_next_valid_o, load_rdata_o,
                        mon_e.l1, mon_e.l2, mon_e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit g1, g2, glw, need_new;
      zeroInputs();
      clearModel();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_outst", 32'(outst_o), 0);
      checkOutput("rst_discard", 32'(discard_o), 0);
      checkOutput("rst_allowin", 32'(now_allowin_o), 1);
      checkOutput("rst_line1", 32'(line1_to_next_valid_o), 0);
      checkOutput("rst_line2", 32'(line2_to_next_valid_o), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic load: request, then response with WB ready.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 0, 1, 0, 1, 32'h1234_5678, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);

      // WB stalled for three cycles: buffered data must hold while rdata_i moves.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 1, 1, 0, 1, 32'h1234_5678, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, $urandom, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, $urandom, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, $urandom, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 32'h5555_AAAA, 0, 1);

      // Flush with two in flight: both later responses are swallowed.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 1);
      applyStimulus(1, 0, 1, 0, 1, 32'hDEAD_0001, 0, 1);
      applyStimulus(1, 0, 1, 0, 1, 32'hDEAD_0002, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 0, 1, 0, 1, 32'hCAFE_F00D, 0, 1);

      // Flush coinciding with a live response at two outstanding.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 0, 1, 0, 1, 32'hBEEF_0001, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);

      // Counter saturation and simultaneous request/response.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 1, 1, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);

      // Asynchronous reset while buffering with a request outstanding.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(1, 0, 1, 0, 1, 32'hA5A5_0001, 0, 0);
      applyStimulus(1, 0, 1, 1, 0, 32'h0, 0, 0);
      @(posedge clk);
      #1;
      req_accept_i = 1'b0;
      rdata_i      = 32'h0BAD_0BAD;
      #1;
      checkOutput("buf_hold", load_rdata_o, 32'hA5A5_0001);
      checkOutput("buf_outst", 32'(outst_o), 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_outst", 32'(outst_o), 0);
      checkOutput("async_discard", 32'(discard_o), 0);
      checkOutput("async_rdata", load_rdata_o, 32'h0BAD_0BAD);
      checkOutput("async_allowin", 32'(now_allowin_o), 0);
      checkOutput("async_line1", 32'(line1_to_next_valid_o), 0);
      zeroInputs();
      #1;
      checkOutput("async_allowin_idle", 32'(now_allowin_o), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clearModel();

      // Asynchronous reset while stale responses are pending.
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 1, 1);
      @(posedge clk);
      #1;
      zeroInputs();
      checkOutput("pre_rst_discard", 32'(discard_o), 2);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_discard_clr", 32'(discard_o), 0);
      checkOutput("rst_outst_clr", 32'(outst_o), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clearModel();

      // Randomized traffic: a group stays in MEM until it leaves or is flushed.
      need_new = 1'b1;
      g1 = 1'b0; g2 = 1'b0; glw = 1'b0;
      for (int i = 0; i < 600; i++) begin
         bit req, dok, flush, na;
         if (need_new) begin
            g1  = $urandom_range(0, 1) == 1;
            g2  = $urandom_range(0, 1) == 1;
            glw = (g1 | g2) && ($urandom_range(0, 2) != 0);
         end
         req   = $urandom_range(0, 2) == 0;
         dok   = (pend_q.size() > 0) && ($urandom_range(0, 2) == 0);
         flush = $urandom_range(0, 15) == 0;
         na    = $urandom_range(0, 3) != 0;
         applyStimulus(g1, g2, glw, req, dok, $urandom, flush, na);
         need_new = exp_allowin || flush;
      end

      resetDut();
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 32'h0, 0, 1);
      checkOutput("sb_drained", 32'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
